// File: rtl/io_hub_pkg.sv
// io_hub_pkg: shared constants for the I/O hub DMA block.
//   - CSR word addresses
//   - CTRL and STATUS bit positions
//   - DMA FSM state encoding
package io_hub_pkg;

  // CSR word addresses
  localparam int unsigned IO_HUB_CTRL       = 0;
  localparam int unsigned IO_HUB_STATUS     = 1;
  localparam int unsigned IO_HUB_ADDR_FIRST = 2;
  localparam int unsigned IO_HUB_ADDR_END   = 3;
  localparam int unsigned IO_HUB_COUNT      = 4;

  // CTRL bits
  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_WRAP    = 1;
  localparam int unsigned CTRL_FLUSH   = 2;
  localparam int unsigned CTRL_IRQ_ENA = 3;

  // STATUS bits
  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_DONE      = 1;
  localparam int unsigned ST_EMPTY     = 2;
  localparam int unsigned ST_FULL      = 3;
  localparam int unsigned ST_ERR       = 4;
  localparam int unsigned ST_WRAPPED   = 5;
  localparam int unsigned ST_LEVEL_LSB = 8;
  localparam int unsigned ST_LEVEL_W   = 8;

  // DMA FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REQ  = 2'd2,
    S_DONE = 2'd3
  } dma_state_e;

endpackage

// File: rtl/io_hub_fifo.sv
// io_hub_fifo: synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   flush        empty the FIFO (wins over push/pop)
//   push, din    write a word (accepted when not full, or when popping)
//   pop          drop the head word (ignored when empty)
//   dout         head word, valid while !empty
//   full, empty  status flags
//   level        number of stored words
module io_hub_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          push_c, pop_c;

  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  assign level  = level_q;
  assign dout   = mem_q[rd_ptr_q];
  assign pop_c  = pop & ~empty;
  // A full FIFO can still take a word in the cycle it releases one.
  assign push_c = push & (~full | pop_c);

  // Storage, pointers and level; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_q + LW'(push_c) - LW'(pop_c);
    end
  end

endmodule

// File: rtl/io_hub_dma.sv
// io_hub_dma: buffers an inbound word stream and drains it to a programmable
// address window over a Wishbone-style DMA master, single-shot or circular.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   src_valid_i/ready_o/data_i     inbound stream
//   io_stb_i/we_i/addr_i/data_i    CSR slave request
//   io_ack_o/io_data_o             CSR acknowledge and read data
//   dma_cyc_o/stb_o/we_o/addr_o/data_o, dma_ack_i   DMA master port
//   irq_o                          interrupt
// Optional: define IO_HUB_DMA_IRQ_EN for CTRL.IRQ_ENA, STATUS.WRAPPED and irq_o.
module io_hub_dma
  import io_hub_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 16,
  parameter int unsigned IO_AW = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             src_valid_i,
  output logic             src_ready_o,
  input  logic [DW-1:0]    src_data_i,
  input  logic             io_stb_i,
  input  logic             io_we_i,
  input  logic [IO_AW-1:0] io_addr_i,
  input  logic [DW-1:0]    io_data_i,
  output logic             io_ack_o,
  output logic [DW-1:0]    io_data_o,
  output logic             dma_cyc_o,
  output logic             dma_stb_o,
  output logic             dma_we_o,
  input  logic             dma_ack_i,
  output logic [AW-1:0]    dma_addr_o,
  output logic [DW-1:0]    dma_data_o,
  output logic             irq_o
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  dma_state_e    state_q, state_d;
  logic [AW-1:0] cur_addr_q, count_q, addr_first_q, addr_end_q;
  logic          wrap_q, done_q, err_q, abort_q, io_ack_q, stb_q;
  logic [DW-1:0] io_rdata_q;

  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [DW-1:0] fifo_head;
  logic          push_c, pop_c, fifo_flush_c;

  logic access_c, wr_c, busy_c, start_c, flush_c;
  logic sel_ctrl_c, sel_status_c, sel_first_c, sel_end_c, sel_count_c;
  logic load_c, set_err_c, clr_flags_c, set_done_c, adv_c, rewind_c;
  logic abort_set_c, abort_clr_c, wrapped_c;
  logic [DW-1:0] status_c, rdata_c;
  logic unused_c;

  // Only some write-data bits are meaningful; fold the rest away.
  assign unused_c = ^io_data_i;

  // CSR decode: a request is taken when strobed with no ack outstanding.
  assign access_c     = io_stb_i & ~io_ack_q;
  assign wr_c         = access_c & io_we_i;
  assign sel_ctrl_c   = (io_addr_i == IO_AW'(IO_HUB_CTRL));
  assign sel_status_c = (io_addr_i == IO_AW'(IO_HUB_STATUS));
  assign sel_first_c  = (io_addr_i == IO_AW'(IO_HUB_ADDR_FIRST));
  assign sel_end_c    = (io_addr_i == IO_AW'(IO_HUB_ADDR_END));
  assign sel_count_c  = (io_addr_i == IO_AW'(IO_HUB_COUNT));
  assign start_c      = wr_c & sel_ctrl_c & io_data_i[CTRL_START];
  assign flush_c      = wr_c & sel_ctrl_c & io_data_i[CTRL_FLUSH];
  assign busy_c       = (state_q != S_IDLE);

  // Stream input; pushes are dropped in the cycle the FIFO is flushed.
  assign push_c      = src_valid_i & ~fifo_full & ~fifo_flush_c;
  assign src_ready_o = ~fifo_full;

  io_hub_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush_c),
    .push  (push_c),
    .pop   (pop_c),
    .din   (src_data_i),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and datapath controls
  always_comb begin
    state_d      = state_q;
    load_c       = 1'b0;
    set_err_c    = 1'b0;
    clr_flags_c  = 1'b0;
    set_done_c   = 1'b0;
    pop_c        = 1'b0;
    adv_c        = 1'b0;
    rewind_c     = 1'b0;
    fifo_flush_c = 1'b0;
    abort_set_c  = 1'b0;
    abort_clr_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_c) begin
          fifo_flush_c = 1'b1;
          clr_flags_c  = 1'b1;
        end else if (start_c) begin
          if (addr_end_q < addr_first_q) begin
            set_err_c = 1'b1;
          end else begin
            load_c      = 1'b1;
            clr_flags_c = 1'b1;
            state_d     = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush_c | abort_q) begin
          fifo_flush_c = 1'b1;
          abort_clr_c  = 1'b1;
          state_d      = S_IDLE;
        end else if (!fifo_empty) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (dma_ack_i) begin
          pop_c = 1'b1;
          // An abort requested during the beat lands here, after the beat counts.
          if (flush_c | abort_q) begin
            fifo_flush_c = 1'b1;
            abort_clr_c  = 1'b1;
            state_d      = S_IDLE;
          end else if (cur_addr_q == addr_end_q) begin
            if (wrap_q) begin
              rewind_c = 1'b1;
              state_d  = S_WAIT;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            adv_c   = 1'b1;
            state_d = S_WAIT;
          end
        end else if (flush_c) begin
          abort_set_c = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (flush_c) fifo_flush_c = 1'b1;
        else         set_done_c   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transfer datapath, sticky flags and CSR registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr_q   <= '0;
      count_q      <= '0;
      addr_first_q <= '0;
      addr_end_q   <= '0;
      wrap_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      abort_q      <= 1'b0;
      io_ack_q     <= 1'b0;
      io_rdata_q   <= '0;
      stb_q        <= 1'b0;
    end else begin
      if (load_c) begin
        cur_addr_q <= addr_first_q;
        count_q    <= '0;
      end else begin
        if (rewind_c)   cur_addr_q <= addr_first_q;
        else if (adv_c) cur_addr_q <= cur_addr_q + AW'(1);
        if (pop_c)      count_q    <= count_q + AW'(1);
      end

      if (clr_flags_c) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        if (set_done_c) done_q <= 1'b1;
        if (set_err_c)  err_q  <= 1'b1;
      end

      if (abort_clr_c)      abort_q <= 1'b0;
      else if (abort_set_c) abort_q <= 1'b1;

      // Window and mode are frozen while a transfer is running.
      if (wr_c && !busy_c) begin
        if (sel_first_c) addr_first_q <= io_data_i[AW-1:0];
        if (sel_end_c)   addr_end_q   <= io_data_i[AW-1:0];
        if (sel_ctrl_c)  wrap_q       <= io_data_i[CTRL_WRAP];
      end

      io_ack_q   <= access_c;
      io_rdata_q <= (access_c && !io_we_i) ? rdata_c : '0;
      stb_q      <= (state_d == S_REQ);
    end
  end

`ifdef IO_HUB_DMA_IRQ_EN
  logic irq_ena_q, wrapped_q, irq_q;

  // Interrupt enable, wrap event latch and level interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_ena_q <= 1'b0;
      wrapped_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_c && sel_ctrl_c) irq_ena_q <= io_data_i[CTRL_IRQ_ENA];
      if (rewind_c)
        wrapped_q <= 1'b1;
      else if (wr_c && sel_status_c && io_data_i[ST_WRAPPED])
        wrapped_q <= 1'b0;
      irq_q <= irq_ena_q & (done_q | err_q | wrapped_q);
    end
  end

  assign wrapped_c = wrapped_q;
  assign irq_o     = irq_q;
`else
  assign wrapped_c = 1'b0;
  assign irq_o     = 1'b0;
`endif

  // STATUS word and CSR read mux
  always_comb begin
    status_c             = '0;
    status_c[ST_BUSY]    = busy_c;
    status_c[ST_DONE]    = done_q;
    status_c[ST_EMPTY]   = fifo_empty;
    status_c[ST_FULL]    = fifo_full;
    status_c[ST_ERR]     = err_q;
    status_c[ST_WRAPPED] = wrapped_c;
    status_c[ST_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(fifo_level);

    rdata_c = '0;
    if (sel_status_c)     rdata_c = status_c;
    else if (sel_first_c) rdata_c = DW'(addr_first_q);
    else if (sel_end_c)   rdata_c = DW'(addr_end_q);
    else if (sel_count_c) rdata_c = DW'(count_q);
  end

  assign io_ack_o   = io_ack_q;
  assign io_data_o  = io_rdata_q;
  assign dma_cyc_o  = stb_q;
  assign dma_stb_o  = stb_q;
  assign dma_we_o   = stb_q;
  assign dma_addr_o = cur_addr_q;
  assign dma_data_o = fifo_head;

endmodule

// File: tb/tb_io_hub_dma.sv
// Scoreboard bench for io_hub_dma: directed stimulus pushes expected DMA beats
// and CSR read values into queues; monitors pop and compare as the DUT responds.
module tb_io_hub_dma;

  localparam int unsigned DW = 32, AW = 16, IO_AW = 16, DEPTH = 8;

`ifdef IO_HUB_DMA_IRQ_EN
  localparam logic [31:0] WRP = 32'h20;
  localparam logic [31:0] IEN = 32'h08;
  localparam logic [31:0] IRQ_EXP = 32'h1;
`else
  localparam logic [31:0] WRP = 32'h00;
  localparam logic [31:0] IEN = 32'h00;
  localparam logic [31:0] IRQ_EXP = 32'h0;
`endif

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             src_valid_i = 1'b0, src_ready_o;
  logic [DW-1:0]    src_data_i = '0;
  logic             io_stb_i = 1'b0, io_we_i = 1'b0, io_ack_o;
  logic [IO_AW-1:0] io_addr_i = '0;
  logic [DW-1:0]    io_data_i = '0, io_data_o;
  logic             dma_cyc_o, dma_stb_o, dma_we_o, dma_ack_i = 1'b0;
  logic [AW-1:0]    dma_addr_o;
  logic [DW-1:0]    dma_data_o;
  logic             irq_o;

  int n_checks = 0, n_pass = 0, beats = 0, ack_delay = 0;
  logic [31:0] exp_a_q[$], exp_d_q[$], exp_r_q[$];
  string       name_q[$];
  bit          kind_q[$];

  always #5 clk = ~clk;

  io_hub_dma #(.DW(DW), .AW(AW), .IO_AW(IO_AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .src_data_i(src_data_i),
    .io_stb_i(io_stb_i), .io_we_i(io_we_i), .io_addr_i(io_addr_i),
    .io_data_i(io_data_i), .io_ack_o(io_ack_o), .io_data_o(io_data_o),
    .dma_cyc_o(dma_cyc_o), .dma_stb_o(dma_stb_o), .dma_we_o(dma_we_o),
    .dma_ack_i(dma_ack_i), .dma_addr_o(dma_addr_o), .dma_data_o(dma_data_o),
    .irq_o(irq_o)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic fail_msg(input string nm);
    n_checks++;
    $display("FAIL %s", nm);
  endtask

  task automatic exp_beat(input logic [31:0] a, input logic [31:0] d);
    exp_a_q.push_back(a);
    exp_d_q.push_back(d);
  endtask

  task automatic csr_wr(input int a, input logic [31:0] d);
    kind_q.push_back(1'b0);
    io_stb_i = 1'b1; io_we_i = 1'b1; io_addr_i = IO_AW'(a); io_data_i = d;
    @(posedge clk); #1;
    io_stb_i = 1'b0; io_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic csr_rd(input int a, input logic [31:0] exp, input string nm);
    kind_q.push_back(1'b1);
    exp_r_q.push_back(exp);
    name_q.push_back(nm);
    io_stb_i = 1'b1; io_we_i = 1'b0; io_addr_i = IO_AW'(a);
    @(posedge clk); #1;
    io_stb_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    int t = 0;
    src_valid_i = 1'b1; src_data_i = d;
    @(negedge clk);
    while (!src_ready_o && t < 200) begin @(negedge clk); t++; end
    if (!src_ready_o) fail_msg("push_timeout");
    @(posedge clk); #1;
    src_valid_i = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    int t = 0;
    while (beats < target && t < 500) begin @(negedge clk); t++; end
    if (beats < target) fail_msg("dma_beat_timeout");
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_stb();
    int t = 0;
    while (!dma_stb_o && t < 100) begin @(negedge clk); t++; end
    if (!dma_stb_o) fail_msg("dma_stb_timeout");
  endtask

  // DMA slave responder and beat scoreboard
  initial begin : dma_mon
    bit          in_beat = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] hold_a = '0, hold_d = '0;
    forever begin
      @(negedge clk);
      if (dma_ack_i) begin
        dma_ack_i = 1'b0;
      end else if (!dma_stb_o) begin
        in_beat = 1'b0;
      end else begin
        if (!in_beat) begin
          in_beat = 1'b1; wait_cnt = 0;
          hold_a = 32'(dma_addr_o); hold_d = dma_data_o;
        end else begin
          check("dma_addr_stable", 32'(dma_addr_o), hold_a);
          check("dma_data_stable", dma_data_o, hold_d);
        end
        if (wait_cnt >= ack_delay) begin
          check("dma_cyc_we", {30'd0, dma_cyc_o, dma_we_o}, 32'h3);
          if (exp_a_q.size() == 0) begin
            fail_msg("dma_unexpected_beat");
          end else begin
            check("dma_addr", 32'(dma_addr_o), exp_a_q.pop_front());
            check("dma_data", dma_data_o, exp_d_q.pop_front());
          end
          beats++;
          dma_ack_i = 1'b1;
          in_beat = 1'b0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // CSR response monitor
  initial begin : csr_mon
    forever begin
      @(negedge clk);
      if (io_ack_o) begin
        if (kind_q.size() == 0) fail_msg("csr_unexpected_ack");
        else if (kind_q.pop_front()) check(name_q.pop_front(), io_data_o, exp_r_q.pop_front());
      end
    end
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_src_ready", 32'(src_ready_o), 32'h1);
    check("reset_stb_ack_irq", {29'd0, dma_stb_o, io_ack_o, irq_o}, 32'h0);
    csr_rd(1, 32'h4, "reset_status");
    csr_rd(4, 32'h0, "reset_count");
    csr_rd(2, 32'h0, "reset_addr_first");
    csr_rd(0, 32'h0, "ctrl_reads_zero");

    // Single-shot window 0x10..0x13
    for (int i = 0; i < 4; i++) exp_beat(32'h10 + 32'(i), 32'hA0 + 32'(i));
    csr_wr(2, 32'h10);
    csr_wr(3, 32'h13);
    csr_rd(3, 32'h13, "addr_end_rb");
    csr_wr(0, 32'h1);
    for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
    wait_beats(4);
    csr_rd(1, 32'h6, "t1_status_done");
    csr_rd(4, 32'h4, "t1_count");

    // Circular window 0x20..0x21, six words
    for (int i = 0; i < 6; i++) exp_beat(32'h20 + 32'(i % 2), 32'hB0 + 32'(i));
    csr_wr(2, 32'h20);
    csr_wr(3, 32'h21);
    csr_wr(0, 32'h3 | IEN);
    for (int i = 0; i < 6; i++) push_word(32'hB0 + 32'(i));
    wait_beats(10);
    csr_rd(1, 32'h5 | WRP, "t2_status_busy_wrap");
    csr_rd(4, 32'h6, "t2_count");
    check("t2_irq", 32'(irq_o), IRQ_EXP);
    csr_wr(0, 32'h4);
    csr_wr(0, 32'h0);
    csr_wr(1, 32'h20);
    csr_rd(1, 32'h4, "t2_status_after_flush");
    check("t2_irq_cleared", 32'(irq_o), 32'h0);

    // Fill to full with no transfer running
    for (int i = 0; i < 8; i++) push_word(32'hC0 + 32'(i));
    @(negedge clk);
    check("t3_ready_low_full", 32'(src_ready_o), 32'h0);
    src_valid_i = 1'b1; src_data_i = 32'hC8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_ninth_held_off", 32'(src_ready_o), 32'h0);
    end
    #1 src_valid_i = 1'b0;
    csr_rd(1, 32'h808, "t3_status_full_level8");
    for (int i = 0; i < 9; i++) exp_beat(32'h40 + 32'(i), 32'hC0 + 32'(i));
    csr_wr(2, 32'h40);
    csr_wr(3, 32'h48);
    csr_wr(0, 32'h1);
    push_word(32'hC8);
    wait_beats(19);
    csr_rd(1, 32'h6, "t3_status_done");
    csr_rd(4, 32'h9, "t3_count");

    // Slow slave: five stall cycles per beat
    ack_delay = 5;
    exp_beat(32'h50, 32'hD0);
    exp_beat(32'h51, 32'hD1);
    csr_wr(2, 32'h50);
    csr_wr(3, 32'h51);
    csr_wr(0, 32'h1);
    push_word(32'hD0);
    push_word(32'hD1);
    wait_beats(21);
    csr_rd(1, 32'h6, "t4_status_done");
    csr_rd(4, 32'h2, "t4_count_one_pop_per_ack");

    // Inverted window
    ack_delay = 0;
    csr_wr(2, 32'h30);
    csr_wr(3, 32'h2F);
    csr_wr(0, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    csr_rd(1, 32'h16, "t5_status_err");
    csr_rd(4, 32'h2, "t5_count_untouched");
    csr_wr(0, 32'h4);
    csr_rd(1, 32'h4, "t5_flush_clears_err");

    // FLUSH while a beat is stalled
    ack_delay = 6;
    exp_beat(32'h60, 32'hE0);
    csr_wr(2, 32'h60);
    csr_wr(3, 32'h63);
    csr_wr(0, 32'h1);
    push_word(32'hE0);
    push_word(32'hE1);
    wait_stb();
    csr_wr(0, 32'h4);
    check("t6_stb_held_after_flush", 32'(dma_stb_o), 32'h1);
    wait_beats(22);
    repeat (6) @(posedge clk);
    #1;
    csr_rd(1, 32'h4, "t6_status_aborted");
    csr_rd(4, 32'h1, "t6_count");

    // Reset in the middle of a beat
    ack_delay = 100;
    csr_wr(2, 32'h70);
    csr_wr(3, 32'h71);
    csr_wr(0, 32'h1);
    push_word(32'hF0);
    wait_stb();
    #2 rst_n = 1'b0;
    #1 check("t7_stb_drops_in_reset", 32'(dma_stb_o), 32'h0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    ack_delay = 0;
    @(posedge clk); #1;
    check("t7_ready_after_reset", 32'(src_ready_o), 32'h1);
    csr_rd(1, 32'h4, "t7_status");
    csr_rd(2, 32'h0, "t7_addr_first");
    csr_rd(3, 32'h0, "t7_addr_end");
    csr_rd(4, 32'h0, "t7_count");

    repeat (4) @(posedge clk);
    check("dma_scoreboard_drained", 32'(exp_a_q.size()), 32'h0);
    check("csr_scoreboard_drained", 32'(kind_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
